// File: rtl/host_frame_pkg.sv
// rtl/host_frame_pkg.sv - shared types and constants for the host UART frame assembler
// Purpose: frame geometry constants, FSM state encoding and the helper that maps
//          a payload byte index to the MSB position of that byte in the frame.
// Ports:   none (package).
package host_frame_pkg;

  localparam int unsigned MAX_BYTES  = 128;
  localparam int unsigned FRAME_BITS = MAX_BYTES * 8;
  localparam int unsigned CNT_W      = $clog2(MAX_BYTES + 1);
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    LAUNCH,
    WAIT_LOW,
    WAIT_HIGH
  } state_t;

  // Payload byte 0 lands in the frame MSBs, so byte k starts at FRAME_BITS-1-8k.
  function automatic logic [BIT_W-1:0] byte_msb(input logic [CNT_W-1:0] idx);
    return BIT_W'(FRAME_BITS - 1 - 8 * 32'(idx));
  endfunction

endpackage

// File: rtl/host_uart_frame_assembler_if.sv
// rtl/host_uart_frame_assembler_if.sv - UART-side and pipeline-side signals of the frame assembler
// Purpose: bundles the byte input, pipeline handshake and status outputs.
// Ports:   master drives rx_byte/rx_valid/pipe_done/pipe_error and observes the rest;
//          slave (the assembler) is the mirror image.
interface host_uart_frame_assembler_if;
  import host_frame_pkg::*;

  logic [7:0]            rx_byte;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  pipe_done;
  logic                  pipe_error;
  logic [FRAME_BITS-1:0] frame_data;
  logic                  send_packet;
  logic                  frame_done;
  logic                  frame_error;
  logic                  overrun;

  modport master (
    output rx_byte, rx_valid, pipe_done, pipe_error,
    input  rx_ready, frame_data, send_packet, frame_done, frame_error, overrun
  );

  modport slave (
    input  rx_byte, rx_valid, pipe_done, pipe_error,
    output rx_ready, frame_data, send_packet, frame_done, frame_error, overrun
  );

endinterface

// File: rtl/host_frame_timeout_counter.sv
// rtl/host_frame_timeout_counter.sv - saturating inter-byte idle timer
// Purpose: counts idle cycles while enabled and flags the cycle on which the
//          idle gap reaches TIMEOUT_CYCLES.
// Ports:   clk, reset (sync, active-high), clear (restart from 0),
//          enable (count this cycle), expired (combinational pulse on the
//          enabled cycle whose count equals TIMEOUT_CYCLES-1).
module host_frame_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] timer;

  // Holds at LAST rather than wrapping, so a stuck enable cannot re-arm silently.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      timer <= '0;
    end else if (enable && (timer != LAST)) begin
      timer <= timer + W'(1);
    end
  end

  assign expired = enable && (timer == LAST);

endmodule

// File: rtl/host_uart_frame_assembler.sv
// rtl/host_uart_frame_assembler.sv - collects UART bytes into a command frame and launches it
// Purpose: length-prefixed frame capture, launch pulse, pipeline completion
//          tracking and error/overrun reporting.
// Ports:   clk, reset (sync, active-high), bus (slave modport): rx_byte/rx_valid/
//          rx_ready byte input, pipe_done/pipe_error pipeline status, frame_data,
//          send_packet, frame_done, frame_error and sticky overrun outputs.
module host_uart_frame_assembler
  import host_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         reset,
  host_uart_frame_assembler_if.slave   bus
);

  state_t                state, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  send_q, send_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  ovr_q, ovr_d;
  logic                  accepting;
  logic                  tmo_expired;

  assign accepting = (state == IDLE) || (state == COLLECT);

  // Timer only runs on idle COLLECT cycles; any byte, or leaving COLLECT, restarts it.
  host_frame_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state != COLLECT) || bus.rx_valid),
    .enable  ((state == COLLECT) && !bus.rx_valid),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      frame_q <= '0;
      len_q   <= '0;
      count_q <= '0;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_d;
      frame_q <= frame_d;
      len_q   <= len_d;
      count_q <= count_d;
      send_q  <= send_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state;
    frame_d = frame_q;
    len_d   = len_q;
    count_d = count_q;
    send_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    // Bytes offered while not accepting are dropped; the flag is sticky until reset.
    ovr_d   = ovr_q | (bus.rx_valid & ~accepting);

    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          if ((bus.rx_byte == 8'd0) || (32'(bus.rx_byte) > MAX_BYTES)) begin
            err_d = 1'b1;
          end else begin
            frame_d = '0;
            len_d   = CNT_W'(bus.rx_byte);
            count_d = '0;
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (bus.rx_valid) begin
          frame_d[byte_msb(count_q) -: 8] = bus.rx_byte;
          count_d = count_q + CNT_W'(1);
          if (count_q == (len_q - CNT_W'(1))) begin
            send_d  = 1'b1;
            state_d = LAUNCH;
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          frame_d = '0;
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.pipe_done) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (bus.pipe_done) begin
          done_d  = 1'b1;
          err_d   = bus.pipe_error;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rx_ready    = accepting && !reset;
  assign bus.frame_data  = frame_q;
  assign bus.send_packet = send_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_error = err_q;
  assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_host_uart_frame_assembler.sv
// tb/tb_host_uart_frame_assembler.sv - directed self-checking bench for host_uart_frame_assembler
module tb_host_uart_frame_assembler;
  import host_frame_pkg::*;

  localparam int unsigned TMO = 100;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail = 0;
  int   send_count = 0;
  logic [FRAME_BITS-1:0] exp_f;

  host_uart_frame_assembler_if bus ();

  host_uart_frame_assembler #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.send_packet === 1'b1) send_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [FRAME_BITS-1:0] obs,
                             input logic [FRAME_BITS-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed_top=%h expected_top=%h differing_bits=%0d",
             tag, obs[FRAME_BITS-1 -: 128], exp[FRAME_BITS-1 -: 128], $countones(obs ^ exp));
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.rx_byte    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.pipe_done  = 1'b1;
    bus.pipe_error = 1'b0;

    // Reset state
    ticks(2);
    check("rst_rx_ready", bus.rx_ready, 1'b0);
    check("rst_send", bus.send_packet, 1'b0);
    check("rst_done", bus.frame_done, 1'b0);
    check("rst_err", bus.frame_error, 1'b0);
    check("rst_overrun", bus.overrun, 1'b0);
    check_frame("rst_frame", bus.frame_data, '0);
    reset = 1'b0;
    #1;
    check("rst_rx_ready_after", bus.rx_ready, 1'b1);

    // Good frame: L=2, 00 01
    send_byte(8'd2);
    check("good_len_noerr", bus.frame_error, 1'b0);
    send_byte(8'h00);
    check("good_send_early", bus.send_packet, 1'b0);
    send_byte(8'h01);
    check("good_send", bus.send_packet, 1'b1);
    check("good_rx_ready_launch", bus.rx_ready, 1'b0);
    exp_f = '0;
    exp_f[FRAME_BITS-1 -: 16] = 16'h0001;
    check_frame("good_frame", bus.frame_data, exp_f);
    bus.pipe_done = 1'b0;
    tick();
    check("good_send_one_cycle", bus.send_packet, 1'b0);
    check("good_rx_ready_wait", bus.rx_ready, 1'b0);
    tick();
    bus.pipe_done = 1'b1;
    tick();
    check("good_done", bus.frame_done, 1'b1);
    check("good_err", bus.frame_error, 1'b0);
    check_frame("good_frame_held", bus.frame_data, exp_f);
    tick();
    check("good_done_pulse", bus.frame_done, 1'b0);
    check("good_rx_ready_idle", bus.rx_ready, 1'b1);
    check("good_send_count", 64'(send_count), 64'd1);

    // Bad lengths: 0 then 129
    send_byte(8'd0);
    check("badlen0_err", bus.frame_error, 1'b1);
    check("badlen0_rx_ready", bus.rx_ready, 1'b1);
    tick();
    check("badlen0_err_pulse", bus.frame_error, 1'b0);
    send_byte(8'd129);
    check("badlen129_err", bus.frame_error, 1'b1);
    tick();
    check("badlen129_err_pulse", bus.frame_error, 1'b0);
    check("badlen_send_count", 64'(send_count), 64'd1);
    check_frame("badlen_frame_held", bus.frame_data, exp_f);

    // Timeout: byte on the expiry cycle wins, then a full idle gap expires
    send_byte(8'd4);
    check_frame("tmo_frame_cleared", bus.frame_data, '0);
    send_byte(8'hA1);
    send_byte(8'hB2);
    ticks(TMO - 1);
    check("tmo_not_yet", bus.frame_error, 1'b0);
    send_byte(8'hC3);
    check("tmo_byte_wins_err", bus.frame_error, 1'b0);
    check("tmo_byte_wins_ready", bus.rx_ready, 1'b1);
    check("tmo_bytes", 64'(bus.frame_data[FRAME_BITS-1 -: 24]), 64'hA1B2C3);
    ticks(TMO - 1);
    check("tmo_not_yet2", bus.frame_error, 1'b0);
    tick();
    check("tmo_err", bus.frame_error, 1'b1);
    check_frame("tmo_frame_zero", bus.frame_data, '0);
    check("tmo_rx_ready", bus.rx_ready, 1'b1);
    tick();
    check("tmo_err_pulse", bus.frame_error, 1'b0);
    check("tmo_send_count", 64'(send_count), 64'd1);

    // Overrun in WAIT_LOW, then pipe error at completion
    check("ovr_before", bus.overrun, 1'b0);
    send_byte(8'd2);
    send_byte(8'h5A);
    send_byte(8'hC3);
    check("perr_send", bus.send_packet, 1'b1);
    exp_f = '0;
    exp_f[FRAME_BITS-1 -: 16] = 16'h5AC3;
    bus.pipe_done = 1'b0;
    tick();
    send_byte(8'hAA);
    check("ovr_set", bus.overrun, 1'b1);
    check_frame("ovr_frame_unchanged", bus.frame_data, exp_f);
    bus.pipe_done  = 1'b1;
    bus.pipe_error = 1'b1;
    tick();
    bus.pipe_error = 1'b0;
    check("perr_done", bus.frame_done, 1'b1);
    check("perr_err", bus.frame_error, 1'b1);
    tick();
    check("perr_done_pulse", bus.frame_done, 1'b0);
    check("perr_err_pulse", bus.frame_error, 1'b0);
    check("perr_send_count", 64'(send_count), 64'd2);

    // Next good frame: overrun stays sticky
    send_byte(8'd1);
    send_byte(8'h7E);
    check("sticky_send", bus.send_packet, 1'b1);
    bus.pipe_done = 1'b0;
    ticks(2);
    bus.pipe_done = 1'b1;
    tick();
    check("sticky_done", bus.frame_done, 1'b1);
    check("sticky_err", bus.frame_error, 1'b0);
    check("sticky_overrun", bus.overrun, 1'b1);
    tick();

    // Reset mid-COLLECT, then a fresh L=1 frame
    send_byte(8'd3);
    send_byte(8'h11);
    reset = 1'b1;
    tick();
    check("midrst_rx_ready", bus.rx_ready, 1'b0);
    check_frame("midrst_frame", bus.frame_data, '0);
    check("midrst_overrun", bus.overrun, 1'b0);
    check("midrst_err", bus.frame_error, 1'b0);
    check("midrst_send", bus.send_packet, 1'b0);
    check("midrst_done", bus.frame_done, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("midrst_rx_ready_after", bus.rx_ready, 1'b1);
    send_byte(8'd1);
    send_byte(8'h22);
    check("fresh_send", bus.send_packet, 1'b1);
    exp_f = '0;
    exp_f[FRAME_BITS-1 -: 8] = 8'h22;
    check_frame("fresh_frame", bus.frame_data, exp_f);
    bus.pipe_done = 1'b0;
    ticks(2);
    bus.pipe_done = 1'b1;
    tick();
    check("fresh_done", bus.frame_done, 1'b1);
    check("fresh_err", bus.frame_error, 1'b0);
    check("fresh_send_count", 64'(send_count), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
